// File: rtl/linebuf_pkg.sv
// rtl/linebuf_pkg.sv - shared constants, pixel type and lane helper for the multi-line buffer
// Purpose: common definitions imported by line_ram and multi_line_buffer.
//   LINEBUF_MAX_NLINES : largest supported number of line delays / lanes
//   LINEBUF_CNT_W      : width able to hold any line count 0..LINEBUF_MAX_NLINES
//   pix_t              : default-width pixel type (modules re-derive it from DWIDTH)
//   lane_live()        : lane-select test, true when a lane has a real stored line behind it
package linebuf_pkg;

  localparam int unsigned LINEBUF_MAX_NLINES = 8;
  localparam int unsigned LINEBUF_CNT_W      = $clog2(LINEBUF_MAX_NLINES + 1);
  localparam int unsigned LINEBUF_DWIDTH_DEF = 8;

  typedef logic [LINEBUF_DWIDTH_DEF-1:0] pix_t;

  // Lane k holds a line from the current image only once more than k complete
  // lines have been stored since reset.
  function automatic logic lane_live(input logic [LINEBUF_CNT_W-1:0] line_cnt,
                                     input int unsigned              lane);
    return int'(line_cnt) > int'(lane);
  endfunction

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - simple dual-port line RAM with one-cycle registered read
// Purpose: one line of pixel storage, depth 1<<WLEVEL, width DWIDTH.
// Ports:
//   clk   : clock
//   we    : write enable; waddr/wdata : write address and data
//   re    : read enable;  raddr       : read address
//   rdata : registered read data, updated only on re, returns old data on a
//           same-cycle write to the same address
module line_ram
  import linebuf_pkg::*;
#(
  parameter int unsigned WLEVEL = 12,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WLEVEL-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [WLEVEL-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << WLEVEL;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/multi_line_buffer.sv
// rtl/multi_line_buffer.sv - NLINES-deep line delay presenting the pixels above the current column
// Purpose: JPEG-LS context path line buffer. Each accepted pixel enters a
//   cascade of NLINES line RAMs; lane k of odata is the pixel k+1 rows above
//   at the same column, one cycle after the pixel is accepted.
// Build option: LINEBUF_ZERO_FILL_EN -- lane k reads as 0 while line_cnt <= k
//   at read time (rows above the image top); otherwise lanes show raw RAM data.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   length   : line length minus 1, latched at column 0
//   ivalid   : pixel accept strobe (no backpressure); idata : pixel
//   ovalid   : odata/ocol updated this cycle
//   ocol     : column of the pixel that produced odata
//   ofilled  : complete lines stored since reset, saturating at NLINES
//   odata    : lane k at bits [k*DWIDTH +: DWIDTH]
module multi_line_buffer
  import linebuf_pkg::*;
#(
  parameter int unsigned WLEVEL = 12,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned NLINES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WLEVEL-1:0]            length,
  input  logic                         ivalid,
  input  logic [DWIDTH-1:0]            idata,
  output logic                         ovalid,
  output logic [WLEVEL-1:0]            ocol,
  output logic [$clog2(NLINES+1)-1:0]  ofilled,
  output logic [NLINES*DWIDTH-1:0]     odata
);

  localparam int unsigned CW = $clog2(NLINES + 1);
  localparam int unsigned OW = NLINES * DWIDTH;

  logic [WLEVEL-1:0] ptr_q, ptr_d;
  logic [WLEVEL-1:0] len_act_q, len_act_d;
  logic [WLEVEL-1:0] rptr_q, rptr_d;
  logic [CW-1:0]     line_cnt_q, line_cnt_d;
  logic              rvalid_q, rvalid_d;
  logic [OW-1:0]     hold_q, hold_d;

  logic [WLEVEL-1:0] len_eff;
  logic              wrap;
  logic [OW-1:0]     lane_data;
  logic [DWIDTH-1:0] rd_data [NLINES];

`ifdef LINEBUF_ZERO_FILL_EN
  logic [NLINES-1:0] zmask_q, zmask_d;
`endif

  always_comb begin
    // At column 0 the new length takes effect immediately, so a one-pixel
    // compare against the latched value would be stale.
    len_eff    = (ptr_q == '0) ? length : len_act_q;
    wrap       = (ptr_q == len_eff);

    ptr_d      = ptr_q;
    len_act_d  = len_act_q;
    line_cnt_d = line_cnt_q;
    rptr_d     = rptr_q;
    rvalid_d   = ivalid;

    if (ivalid) begin
      rptr_d = ptr_q;
      if (ptr_q == '0) begin
        len_act_d = length;
      end
      if (wrap) begin
        ptr_d = '0;
        if (line_cnt_q != CW'(NLINES)) begin
          line_cnt_d = line_cnt_q + CW'(1);
        end
      end else begin
        ptr_d = ptr_q + WLEVEL'(1);
      end
    end

    // The hold register tracks the last completed read so odata is stable
    // between ovalid pulses and is zero after reset.
    hold_d = rvalid_q ? lane_data : hold_q;
  end

`ifdef LINEBUF_ZERO_FILL_EN
  // Lane liveness is captured alongside the RAM read so it refers to the
  // line count before this pixel's own wrap.
  always_comb begin
    zmask_d = zmask_q;
    if (ivalid) begin
      for (int k = 0; k < NLINES; k++) begin
        zmask_d[k] = lane_live(LINEBUF_CNT_W'(line_cnt_q), k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zmask_q <= '0;
    end else begin
      zmask_q <= zmask_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      len_act_q  <= '0;
      rptr_q     <= '0;
      line_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      hold_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      len_act_q  <= len_act_d;
      rptr_q     <= rptr_d;
      line_cnt_q <= line_cnt_d;
      rvalid_q   <= rvalid_d;
      hold_q     <= hold_d;
    end
  end

  // Cascade: every line is read at ptr on accept; one cycle later line k+1
  // stores what line k returned, at the same column. A same-address
  // read/write collision cannot occur because consecutive pixels differ in
  // column whenever length >= 1.
  for (genvar k = 0; k < NLINES; k++) begin : g_line
    logic              we;
    logic [WLEVEL-1:0] waddr;
    logic [DWIDTH-1:0] wdata;

    if (k == 0) begin : g_head
      assign we    = ivalid;
      assign waddr = ptr_q;
      assign wdata = idata;
    end else begin : g_tail
      assign we    = rvalid_q;
      assign waddr = rptr_q;
      assign wdata = rd_data[k-1];
    end

    line_ram #(
      .WLEVEL (WLEVEL),
      .DWIDTH (DWIDTH)
    ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re    (ivalid),
      .raddr (ptr_q),
      .rdata (rd_data[k])
    );

`ifdef LINEBUF_ZERO_FILL_EN
    assign lane_data[k*DWIDTH +: DWIDTH] = zmask_q[k] ? rd_data[k] : '0;
`else
    assign lane_data[k*DWIDTH +: DWIDTH] = rd_data[k];
`endif
  end

  assign ovalid  = rvalid_q;
  assign ocol    = rptr_q;
  assign ofilled = line_cnt_q;
  assign odata   = rvalid_q ? lane_data : hold_q;

endmodule

// File: tb/tb_multi_line_buffer.sv
// tb/tb_multi_line_buffer.sv - scoreboard bench for multi_line_buffer
module tb_multi_line_buffer;
  import linebuf_pkg::*;

  localparam int WL = 12;
  localparam int DW = 8;
  localparam int NL = 4;
  localparam int FW = $clog2(NL + 1);
  localparam int NCOL = 1 << WL;
`ifdef LINEBUF_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WL-1:0]     length = '0;
  logic              ivalid = 1'b0;
  logic [DW-1:0]     idata = '0;
  logic              ovalid;
  logic [WL-1:0]     ocol;
  logic [FW-1:0]     ofilled;
  logic [NL*DW-1:0]  odata;

  multi_line_buffer #(.WLEVEL(WL), .DWIDTH(DW), .NLINES(NL)) dut (
    .clk     (clk),
    .rst     (rst),
    .length  (length),
    .ivalid  (ivalid),
    .idata   (idata),
    .ovalid  (ovalid),
    .ocol    (ocol),
    .ofilled (ofilled),
    .odata   (odata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WL-1:0]    col;
    logic [FW-1:0]    filled;
    logic [NL-1:0]    chk;
    logic [NL*DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: per column, the most recent pixels seen at that column
  // (newest first). Lane k is the (k+1)-th most recent earlier pixel there.
  pix_t hist [NCOL][NL];
  int   depth [NCOL];
  int   m_col = 0;
  int   m_len = 0;
  int   m_rows = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    exp_t e;
    int   c;
    if (m_col == 0) m_len = int'(length);
    c = m_col;
    e.col  = WL'(c);
    e.chk  = '0;
    e.data = '0;
    for (int k = 0; k < NL; k++) begin
      if (ZF && m_rows <= k) begin
        e.chk[k] = 1'b1;
      end else if (depth[c] > k) begin
        e.chk[k] = 1'b1;
        e.data[k*DW +: DW] = hist[c][k];
      end
    end
    for (int k = NL - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
    hist[c][0] = d;
    if (depth[c] < NL) depth[c]++;
    if (m_col == m_len) begin
      m_col = 0;
      if (m_rows < NL) m_rows++;
    end else begin
      m_col++;
    end
    e.filled = FW'(m_rows);
    q.push_back(e);
    ivalid = 1'b1;
    idata  = d;
    @(posedge clk);
    #1;
    ivalid = 1'b0;
  endtask

  task automatic do_reset();
    idle(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_col = 0;
    m_len = 0;
    m_rows = 0;
    @(negedge clk);
    chk("reset_ovalid", 64'(ovalid), 64'd0);
    chk("reset_ocol", 64'(ocol), 64'd0);
    chk("reset_odata", 64'(odata), 64'd0);
    chk("reset_ofilled", 64'(ofilled), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Length 3, stream 0..9; input 9 is row 2 col 1.
  task automatic run_s1();
    length = WL'(3);
    for (int i = 0; i < 10; i++) send(DW'(i));
    @(negedge clk);
    chk("s1_ovalid", 64'(ovalid), 64'd1);
    chk("s1_ocol", 64'(ocol), 64'd1);
    chk("s1_lane0", 64'(odata[0 +: DW]), 64'd5);
    chk("s1_lane1", 64'(odata[DW +: DW]), 64'd1);
    chk("s1_ofilled", 64'(ofilled), 64'd2);
    @(posedge clk);
    #1;
  endtask

  logic [NL*DW-1:0] last_data = '0;
  logic [WL-1:0]    last_col = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_data = '0;
      last_col  = '0;
    end else if (ovalid) begin
      if (q.size() == 0) begin
        chk("spurious_ovalid", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("ocol", 64'(ocol), 64'(e.col));
        chk("ofilled", 64'(ofilled), 64'(e.filled));
        for (int k = 0; k < NL; k++) begin
          if (e.chk[k]) chk($sformatf("lane%0d", k), 64'(odata[k*DW +: DW]), 64'(e.data[k*DW +: DW]));
        end
      end
      last_data = odata;
      last_col  = ocol;
    end else begin
      chk("hold_odata", 64'(odata), 64'(last_data));
      chk("hold_ocol", 64'(ocol), 64'(last_col));
    end
  end

  initial begin
    for (int c = 0; c < NCOL; c++) depth[c] = 0;
    idle(3);
    do_reset();

    // Basic fill (zero-fill rows covered by the model when enabled)
    run_s1();

    // Random gaps
    do_reset();
    length = WL'($urandom_range(1, 9));
    for (int i = 0; i < 6 * (int'(length) + 1); i++) begin
      send(DW'($urandom));
      idle($urandom_range(0, 5));
    end

    // Mid-line length change 3 -> 5 at col 2
    do_reset();
    length = WL'(3);
    for (int i = 0; i < 10; i++) send(DW'($urandom));
    length = WL'(5);
    for (int i = 0; i < 2 + 6 + 6; i++) send(DW'($urandom));

    // Reset mid-line at row 1 col 2, then replay scenario 1
    do_reset();
    length = WL'(3);
    for (int i = 0; i < 6; i++) send(DW'(100 + i));
    do_reset();
    run_s1();

    // Maximum line length, lane 3 reaches four rows back
    do_reset();
    length = WL'(NCOL - 1);
    for (int i = 0; i < 5 * NCOL + 8; i++) send(DW'($urandom));

    idle(4);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
